// File: rtl/lsu_ctrl.sv
// Load/store controller: aligns, checks and sequences core memory accesses,
// using read-modify-write for sub-word stores against a word-wide memory.
module lsu_ctrl #(
    parameter logic [31:0] MEM_LIMIT = 32'd10240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_r_w,
    output logic [31:0] mem_address,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        mem_en_q;
    logic        mem_r_w_q;
    logic [31:0] mem_address_q;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        err_q;
    // Holds store data for word stores, the merged word for RMW, or the loaded word.
    logic [31:0] word_q;

    logic        req_fault;
    logic [31:0] load_d;
    logic [31:0] rmw_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'b11)
            req_fault = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_fault = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if (req_addr >= MEM_LIMIT)
            req_fault = 1'b1;
    end

    always_comb begin
        byte_sel = word_q[8*lane_q +: 8];
        half_sel = lane_q[1] ? word_q[31:16] : word_q[15:0];
        load_d   = word_q;
        case (size_q)
            SZ_BYTE: load_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_d = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_d = word_q;
        endcase
    end

    always_comb begin
        rmw_d = mem_out;
        case (size_q)
            SZ_BYTE: rmw_d[8*lane_q +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (lane_q[1])
                    rmw_d[31:16] = wdata_q;
                else
                    rmw_d[15:0] = wdata_q;
            end
            default: rmw_d = mem_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            resp_valid_q  <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_r_w_q     <= 1'b0;
            mem_address_q <= '0;
            we_q          <= 1'b0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            lane_q        <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            word_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_r_w_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        ready_q       <= 1'b0;
                        we_q          <= req_we;
                        size_q        <= req_size;
                        uns_q         <= req_unsigned;
                        lane_q        <= req_addr[1:0];
                        wdata_q       <= req_wdata[15:0];
                        word_q        <= req_wdata;
                        err_q         <= req_fault;
                        mem_address_q <= {req_addr[31:2], 2'b00};
                        if (req_fault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else if (req_we && req_size == SZ_WORD) begin
                            state_q   <= WRITE;
                            mem_en_q  <= 1'b1;
                            mem_r_w_q <= 1'b1;
                        end else begin
                            state_q  <= READ;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    // Memory data is only valid this cycle; capture it (merged for stores).
                    word_q <= we_q ? rmw_d : mem_out;
                    if (we_q) begin
                        state_q   <= WRITE;
                        mem_en_q  <= 1'b1;
                        mem_r_w_q <= 1'b1;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = (state_q == RESP) && err_q;
    assign resp_rdata  = (state_q == RESP && !we_q && !err_q) ? load_d : '0;
    assign mem_en      = mem_en_q;
    assign mem_r_w     = mem_r_w_q;
    assign mem_address = mem_address_q;
    assign mem_in      = (state_q == WRITE) ? word_q : '0;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter MEM_LIMIT, default 10240: first byte address beyond the memory array; any access at or above it is a fault.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  core requests an access.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended; 0 for stores and faults.
REQ-013 resp_err  output  1  qualifies resp_valid; access faulted.
REQ-014 mem_en  output  1  memory enable.
REQ-015 mem_r_w  output  1  0 = read, 1 = write.
REQ-016 mem_address  output  32  word-aligned address: req_addr with bits [1:0] cleared.
REQ-017 mem_in  output  32  write word.
REQ-018 mem_out  input  32  read word, valid in the cycle after a read-enable cycle; 0 otherwise.

Function
REQ-019 FSM states: IDLE, READ, WAIT, WRITE, RESP.
REQ-020 req_ready = 1 only in IDLE.
REQ-021 Handshake: a request is accepted on a rising edge with req_valid && req_ready; all request fields are latched at that edge.
REQ-022 Fault conditions; any one is a fault:
  - req_size = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_LIMIT.
REQ-023 A faulted request goes IDLE -> RESP with resp_err = 1 and makes no memory access.
REQ-024 Load path: IDLE -> READ -> WAIT -> RESP; resp_valid is asserted 3 cycles after acceptance.
REQ-025 Word-store path: IDLE -> WRITE -> RESP; resp_valid is asserted 2 cycles after acceptance.
REQ-026 Byte/halfword-store path (read-modify-write): IDLE -> READ -> WAIT -> WRITE -> RESP; resp_valid is asserted 4 cycles after acceptance.
REQ-027 READ: mem_en = 1, mem_r_w = 0. WRITE: mem_en = 1, mem_r_w = 1. All other states: mem_en = 0, mem_r_w = 0, mem_in = 0.
REQ-028 WAIT: mem_out is registered into an internal word register; this is the only cycle mem_out is sampled.
REQ-029 Lanes are little-endian:
  - byte k = bits[8k+7:8k], with k = addr[1:0];
  - halfword = bits[31:16] when addr[1] = 1, else bits[15:0].
REQ-030 Load result: the selected lane, extended to 32 bits per req_unsigned; word loads are unmodified.
REQ-031 RMW merge: only the addressed lane is replaced with the low bits of req_wdata; the other lanes keep the read value.
REQ-032 RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_err are driven only in RESP and are 0 otherwise.
REQ-033 A new request may be accepted in the cycle after RESP; there is no back-to-back acceptance in RESP itself.
REQ-034 req_valid asserted outside IDLE is ignored, not queued.

Reset
REQ-035 rst_n low immediately forces, regardless of clk:
  - state = IDLE;
  - req_ready = 1;
  - resp_valid = 0, resp_err = 0, resp_rdata = 0;
  - mem_en = 0, mem_r_w = 0, mem_address = 0, mem_in = 0;
  - latched request registers cleared.
REQ-036 Reset asserted during READ, WAIT or WRITE abandons the access: no write is issued after reset and no response is produced.
REQ-037 The first acceptance is possible on the first rising edge with rst_n high.

Verification
REQ-038 mem[0x800] = 0x80FF7F01; byte load, addr 0x803, signed -> resp_rdata 0xFFFFFF80 at +3 cycles, resp_err = 0.
REQ-039 Same word; halfword load, addr 0x802, unsigned -> 0x000080FF; word load, addr 0x800 -> 0x80FF7F01.
REQ-040 mem[0x804] = 0x11223344; byte store 0xAB to 0x805:
  - one read cycle, then one write cycle with mem_in = 0x1122AB44;
  - resp_valid at +4 cycles.
REQ-041 Word store 0xDEADBEEF to 0x808 -> single write cycle, no read cycle, resp_valid at +2 cycles.
REQ-042 Word load at 0x802, halfword at 0x801, size 11, and addr 10240 -> each gives resp_err = 1 at +1 cycle with mem_en never asserted.
REQ-043 rst_n pulsed low during WAIT of a byte store -> no write cycle, no resp_valid; req_ready = 1 while rst_n is low.
